// File: rtl/addr_match_unit.sv
`default_nettype none
// ============================================================================
//  Module   : adder_comparator / addr_match_unit
//  Purpose  : Pipelined watchpoint unit. Checks base + offset against a set
//             of programmed match addresses without a carry-propagate adder,
//             and returns a registered hit vector, lowest hit index and tag
//             over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================

// Tests a + b == k (mod 2^WIDTH) without forming the sum. If the sum equals
// k, the carry into bit i must be a^b^k at bit i; the carry that bit i-1
// would then produce is (a&b) | ((a^b)&~k). Equality holds exactly when the
// two agree at every bit, with a zero carry into bit 0.
module adder_comparator #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] k,
    output logic             eq
);
    logic [WIDTH-1:0] w_carry_out;
    logic [WIDTH-1:0] w_carry_in;

    assign w_carry_out = (a & b) | ((a ^ b) & ~k);
    assign w_carry_in  = w_carry_out << 1;
    assign eq          = ((a ^ b ^ k) == w_carry_in);
endmodule

module addr_match_unit #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4,
    parameter int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [WIDTH-1:0]   cfg_addr,
    input  logic               cfg_en,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_base,
    input  logic [WIDTH-1:0]   req_offset,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic [ENTRIES-1:0] rsp_hit_vec,
    output logic [IDX_W-1:0]   rsp_hit_idx,
    output logic [TAG_W-1:0]   rsp_tag,
    input  logic               cnt_clr,
    output logic [15:0]        hit_count
);
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    // S1 request register
    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_base;
    logic [WIDTH-1:0]   r_s1_offset;
    logic [TAG_W-1:0]   r_s1_tag;

    // S2 response register
    logic               r_s2_valid;
    logic [ENTRIES-1:0] r_s2_hit_vec;
    logic [IDX_W-1:0]   r_s2_hit_idx;
    logic [TAG_W-1:0]   r_s2_tag;

    logic [15:0]        r_hit_count;

    logic               w_s2_free;
    logic               w_s1_load;
    logic               w_s1_to_s2;
    logic [ENTRIES-1:0] w_hit_vec;
    logic [IDX_W-1:0]   w_hit_idx;

    assign w_s2_free  = !r_s2_valid || rsp_ready;
    assign req_ready  = !r_s1_valid || w_s2_free;
    assign w_s1_load  = req_valid && req_ready;
    assign w_s1_to_s2 = r_s1_valid && w_s2_free;

    // One storage slot and one comparator per entry; an out-of-range cfg_idx
    // equals no slot index and so writes nothing.
    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
            localparam logic [IDX_W-1:0] C_IDX = IDX_W'(g);
            logic [WIDTH-1:0] r_addr;
            logic             r_en;
            logic             w_eq;

            // Entry register, written by the config port
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_addr <= '0;
                    r_en   <= 1'b0;
                end else if (cfg_we && (cfg_idx == C_IDX)) begin
                    r_addr <= cfg_addr;
                    r_en   <= cfg_en;
                end
            end

            adder_comparator #(.WIDTH(WIDTH)) u_cmp (
                .a  (r_s1_base),
                .b  (r_s1_offset),
                .k  (r_addr),
                .eq (w_eq)
            );

            assign w_hit_vec[g] = r_en && w_eq;
        end
    endgenerate

    // Lowest set bit of the hit vector, zero when nothing hits
    always_comb begin
        w_hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // S1: take a new request, or empty out once S2 has taken the contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_base   <= '0;
            r_s1_offset <= '0;
            r_s1_tag    <= '0;
        end else if (w_s1_load) begin
            r_s1_valid  <= 1'b1;
            r_s1_base   <= req_base;
            r_s1_offset <= req_offset;
            r_s1_tag    <= req_tag;
        end else if (w_s1_to_s2) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // S2: capture the compare result; hold everything while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_hit_vec <= '0;
            r_s2_hit_idx <= '0;
            r_s2_tag     <= '0;
        end else if (w_s1_to_s2) begin
            r_s2_valid   <= 1'b1;
            r_s2_hit_vec <= w_hit_vec;
            r_s2_hit_idx <= w_hit_idx;
            r_s2_tag     <= r_s1_tag;
        end else if (rsp_ready) begin
            r_s2_valid   <= 1'b0;
        end
    end

    // Saturating count of delivered hits; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count <= '0;
        end else if (cnt_clr) begin
            r_hit_count <= '0;
        end else if (r_s2_valid && rsp_ready && rsp_hit && (r_hit_count != C_CNT_MAX)) begin
            r_hit_count <= r_hit_count + 16'd1;
        end
    end

    assign rsp_valid   = r_s2_valid;
    assign rsp_hit_vec = r_s2_hit_vec;
    assign rsp_hit     = |r_s2_hit_vec;
    assign rsp_hit_idx = r_s2_hit_idx;
    assign rsp_tag     = r_s2_tag;
    assign hit_count   = r_hit_count;
endmodule
`default_nettype wire

// File: tb/tb_addr_match_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addr_match_unit
//  Purpose  : Self-checking bench for addr_match_unit: directed scenarios
//             plus randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_addr_match_unit;
    localparam int WIDTH = 32;
    localparam int ENTRIES = 4;
    localparam int TAG_W = 4;
    localparam int IDX_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [WIDTH-1:0]   cfg_addr;
    logic               cfg_en;
    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_base;
    logic [WIDTH-1:0]   req_offset;
    logic [TAG_W-1:0]   req_tag;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_hit;
    logic [ENTRIES-1:0] rsp_hit_vec;
    logic [IDX_W-1:0]   rsp_hit_idx;
    logic [TAG_W-1:0]   rsp_tag;
    logic               cnt_clr;
    logic [15:0]        hit_count;

    addr_match_unit #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
        .req_offset(req_offset), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_hit_vec(rsp_hit_vec), .rsp_hit_idx(rsp_hit_idx), .rsp_tag(rsp_tag),
        .cnt_clr(cnt_clr), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ENTRIES-1:0] vec;
        logic [TAG_W-1:0]   tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_addr [ENTRIES];
    logic        m_en   [ENTRIES];
    logic [15:0] m_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Which entries the address base+offset (wrapped to 32 bits) selects
    function automatic logic [ENTRIES-1:0] model_vec(input logic [31:0] b, input logic [31:0] o);
        longint unsigned s;
        logic [ENTRIES-1:0] v;
        s = (longint'(b) + longint'(o)) % (64'd1 << 32);
        v = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (m_en[i] && (s == longint'(m_addr[i]))) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] low_idx(input logic [ENTRIES-1:0] v);
        for (int i = 0; i < ENTRIES; i++)
            if (v[i]) return IDX_W'(i);
        return '0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_cnt = 16'h0;
        for (int i = 0; i < ENTRIES; i++) begin
            m_addr[i] = 32'h0;
            m_en[i] = 1'b0;
        end
    endtask

    // One clock: check outputs against the model mid-cycle, advance the
    // model for the coming edge, then step to just after that edge.
    task automatic tick();
        logic hs;
        logic hit;
        @(negedge clk);
        hit = 1'b0;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                check("rsp_hit_vec", 32'(rsp_hit_vec), 32'(exp_q[0].vec));
                check("rsp_hit", 32'(rsp_hit), 32'(|exp_q[0].vec));
                check("rsp_hit_idx", 32'(rsp_hit_idx), 32'(low_idx(exp_q[0].vec)));
                check("rsp_tag", 32'(rsp_tag), 32'(exp_q[0].tag));
                hit = |exp_q[0].vec;
            end
        end
        check("hit_count", 32'(hit_count), 32'(m_cnt));
        check("req_ready", 32'(req_ready), 32'((exp_q.size() < 2) || rsp_ready));
        hs = rsp_valid && rsp_ready;
        if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
        if (cnt_clr) m_cnt = 16'h0;
        else if (hs && hit && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (cfg_we) begin
            m_addr[cfg_idx] = cfg_addr;
            m_en[cfg_idx] = cfg_en;
        end
        if (req_valid && req_ready) exp_q.push_back('{model_vec(req_base, req_offset), req_tag});
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] a, input logic e);
        cfg_we = 1'b1;
        cfg_idx = IDX_W'(idx);
        cfg_addr = a;
        cfg_en = e;
        tick();
        cfg_we = 1'b0;
    endtask

    // Offer one request, leave the response sitting on the outputs
    task automatic send_one(input logic [31:0] b, input logic [31:0] o, input logic [3:0] t);
        req_valid = 1'b1;
        req_base = b;
        req_offset = o;
        req_tag = t;
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        tick();
        check("drain_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] b;
        logic [31:0] o;
        int pick;
        int guard;
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_en = 1'b0;
        req_valid = 1'b0; req_base = '0; req_offset = '0; req_tag = '0;
        rsp_ready = 1'b1; cnt_clr = 1'b0;
        model_reset();

        // Reset and idle
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_hit_vec", 32'(rsp_hit_vec), 32'h0);
        check("rst_hit_idx", 32'(rsp_hit_idx), 32'h0);
        check("rst_tag", 32'(rsp_tag), 32'h0);
        check("rst_hit_count", 32'(hit_count), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        end

        // Basic hit, with latency
        cfg_write(2, 32'h0000_1000, 1'b1);
        req_valid = 1'b1; req_base = 32'h0000_0FF0; req_offset = 32'h10; req_tag = 4'd5;
        tick();
        req_valid = 1'b0;
        check("lat_not_yet", 32'(rsp_valid), 32'h0);
        tick();
        check("basic_valid", 32'(rsp_valid), 32'h1);
        check("basic_hit", 32'(rsp_hit), 32'h1);
        check("basic_vec", 32'(rsp_hit_vec), 32'h4);
        check("basic_idx", 32'(rsp_hit_idx), 32'h2);
        check("basic_tag", 32'(rsp_tag), 32'h5);
        tick();
        check("basic_count", 32'(hit_count), 32'h1);

        // Wrap-around hit and a plain miss
        cfg_write(0, 32'h0000_0004, 1'b1);
        send_one(32'hFFFF_FFFC, 32'h8, 4'd6);
        check("wrap_hit", 32'(rsp_hit), 32'h1);
        check("wrap_idx", 32'(rsp_hit_idx), 32'h0);
        tick();
        send_one(32'h0000_0004, 32'h1, 4'd7);
        check("miss_hit", 32'(rsp_hit), 32'h0);
        check("miss_vec", 32'(rsp_hit_vec), 32'h0);
        check("miss_idx", 32'(rsp_hit_idx), 32'h0);
        tick();

        // Multiple hits with a disabled entry
        cfg_write(1, 32'h8000, 1'b1);
        cfg_write(3, 32'h8000, 1'b1);
        cfg_write(2, 32'h8000, 1'b0);
        send_one(32'h7000, 32'h1000, 4'd8);
        check("multi_vec", 32'(rsp_hit_vec), 32'hA);
        check("multi_idx", 32'(rsp_hit_idx), 32'h1);
        tick();

        // Backpressure: two buffered, third held off, outputs frozen on tag 1
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_base = 32'h7000; req_offset = 32'h1000;
        req_tag = 4'd1; tick();
        req_tag = 4'd2; tick();
        req_tag = 4'd3;
        for (int i = 0; i < 3; i++) begin
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_rsp_tag", 32'(rsp_tag), 32'h1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check("bp_seq2_valid", 32'(rsp_valid), 32'h1);
        check("bp_seq2_tag", 32'(rsp_tag), 32'h2);
        tick();
        check("bp_seq3_valid", 32'(rsp_valid), 32'h1);
        check("bp_seq3_tag", 32'(rsp_tag), 32'h3);
        tick();
        check("bp_empty", 32'(rsp_valid), 32'h0);

        // Randomized traffic, entries fixed while requests are in flight
        for (int e = 0; e < ENTRIES; e++) cfg_write(e, $urandom, $urandom_range(0, 3) != 0);
        for (int n = 0; n < 400; n++) begin
            b = $urandom;
            pick = $urandom_range(0, ENTRIES - 1);
            o = ($urandom_range(0, 1) == 1) ? (m_addr[pick] - b) : 32'($urandom);
            req_base = b;
            req_offset = o;
            req_tag = 4'($urandom);
            req_valid = $urandom_range(0, 3) != 0;
            rsp_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain();

        // Reset mid-operation discards in-flight requests
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_tag = 4'd9; tick(); tick();
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h1);
        check("midrst_count", 32'(hit_count), 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Counter saturation, then clear racing a hit handshake
        cfg_write(0, 32'h100, 1'b1);
        req_valid = 1'b1; req_base = 32'h100; req_offset = 32'h0; req_tag = 4'd4;
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        check("sat_reached", 32'(m_cnt), 32'hFFFF);
        repeat (3) tick();
        check("sat_hold", 32'(hit_count), 32'hFFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_prio", 32'(hit_count), 32'h0);
        drain();

        // Config write in the same cycle as the S1->S2 transfer
        cfg_write(0, 32'h200, 1'b1);
        req_valid = 1'b1; req_base = 32'h200; req_offset = 32'h0; req_tag = 4'd9;
        tick();
        req_valid = 1'b0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'h300; cfg_en = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("race_valid", 32'(rsp_valid), 32'h1);
        check("race_old_hit", 32'(rsp_hit), 32'h1);
        check("race_tag", 32'(rsp_tag), 32'h9);
        tick();
        send_one(32'h200, 32'h0, 4'd10);
        check("race_new_miss", 32'(rsp_hit), 32'h0);
        tick();
        send_one(32'h2F0, 32'h10, 4'd11);
        check("race_new_hit", 32'(rsp_hit_vec), 32'h1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
